// File: rtl/tmds_word_align.sv
// tmds_word_align: rotates raw deserialised TMDS words by a bit slip that is searched
// autonomously (locking on control-token runs), with a manual slip override for debug.
module tmds_word_align #(
  parameter int WW = 10,
  parameter int SW = $clog2(WW),
  parameter logic [WW-1:0] CTL0 = 10'h354,
  parameter logic [WW-1:0] CTL1 = 10'h0ab,
  parameter logic [WW-1:0] CTL2 = 10'h154,
  parameter logic [WW-1:0] CTL3 = 10'h2ab,
  parameter int LOCK_CNT = 8,
  parameter int SEARCH_TO = 4096,
  parameter int LOSS_TO = 1 << 20
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_manual,
  input  logic [SW-1:0] i_man_slip,
  input  logic [WW-1:0] i_word,
  output logic [WW-1:0] o_word,
  output logic          o_is_ctl,
  output logic [SW-1:0] o_slip,
  output logic          o_locked
);
  localparam int TMAX = (SEARCH_TO > LOSS_TO) ? SEARCH_TO : LOSS_TO;
  localparam int TW = $clog2(TMAX) + 1;
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam logic [SW-1:0] SMAX = SW'(WW - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t          r_state, w_state_nxt;
  logic [2*WW-1:0] r_hist;
  logic [WW-1:0]   w_cand, r_word;
  logic            r_is_ctl, w_match, w_hit, w_to;
  logic [SW-1:0]   r_slip, w_slip_adv, w_man_slip;
  logic [RW-1:0]   r_run, w_run_nxt;
  logic [TW-1:0]   r_tmr;

  // Low half of the history is the newest word, so a slip s pulls s bits from the older word.
  assign w_cand     = WW'(r_hist >> r_slip);
  assign w_match    = (w_cand == CTL0) || (w_cand == CTL1) || (w_cand == CTL2) || (w_cand == CTL3);
  assign w_run_nxt  = !w_match ? '0 : (r_run == RW'(LOCK_CNT)) ? r_run : r_run + 1'b1;
  assign w_hit      = w_run_nxt == RW'(LOCK_CNT);
  assign w_to       = r_tmr == ((r_state == LOCKED) ? TW'(LOSS_TO - 1) : TW'(SEARCH_TO - 1));
  assign w_slip_adv = (r_slip == SMAX) ? '0 : r_slip + 1'b1;
  assign w_man_slip = (i_man_slip > SMAX) ? SMAX : i_man_slip;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= SEARCH;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_manual)  w_state_nxt = SEARCH;
    else if (w_hit) w_state_nxt = LOCKED;
    else if (w_to)  w_state_nxt = SEARCH;
  end

  always_comb begin
    o_locked = (r_state == LOCKED);
  end

  // A completed token run outranks a timeout landing on the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_hist   <= '0;
      r_word   <= '0;
      r_is_ctl <= 1'b0;
      r_slip   <= '0;
      r_run    <= '0;
      r_tmr    <= '0;
    end else begin
      r_hist   <= {r_hist[WW-1:0], i_word};
      r_word   <= w_cand;
      r_is_ctl <= w_match;
      if (i_manual) begin
        r_slip <= w_man_slip;
        r_run  <= '0;
        r_tmr  <= '0;
      end else if (w_hit) begin
        r_run <= w_run_nxt;
        r_tmr <= '0;
      end else if (w_to) begin
        r_slip <= w_slip_adv;
        r_run  <= '0;
        r_tmr  <= '0;
      end else begin
        r_run <= w_run_nxt;
        r_tmr <= r_tmr + 1'b1;
      end
    end
  end

  assign o_word   = r_word;
  assign o_is_ctl = r_is_ctl;
  assign o_slip   = r_slip;
endmodule
